ram_scanner: RTL
================

Name: ram_scanner

Overview:
- Downstream consumer of the game colour RAM (160x120 grid, 3-bit colour per cell, address = {x[7:0], y[6:0]}).
- On each start pulse, sweeps every grid cell in row-major order and reads the cell's colour through an arbitrated RAM port.
- Emits one plot strobe per cell, with coordinates and colour, to the VGA adapter.
- Shares the RAM port with the player-update FSM through a request/grant handshake.

Parameters:
- GRID_W, 160, cells per row; x range 0..GRID_W-1.
- GRID_H, 120, rows; y range 0..GRID_H-1. Addresses with y >= GRID_H are never issued.
- SKIP_BLANK, 0, when 1, cells reading colour 3'b000 produce no plot strobe.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a frame sweep; sampled only in IDLE.
- bus_req  out  1  RAM port request.
- bus_gnt  in  1  RAM port grant from the arbiter.
- address  out  15  RAM address, {x, y}.
- q  in  3  RAM read data; valid the cycle after the address is sampled with bus_gnt=1.
- x  out  8  plot x coordinate.
- y  out  7  plot y coordinate.
- colour  out  3  plot colour.
- plot  out  1  one-cycle plot strobe per cell.
- busy  out  1  high from leaving IDLE until re-entering IDLE.
- frame_done  out  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state IDLE; scan counters 0; pipeline valids 0. Outputs bus_req, plot, busy, frame_done = 0; address, x, y, colour = 0.
- States: IDLE, SCAN, DRAIN, DONE.
  - IDLE: start=1 -> SCAN.
  - SCAN: bus_req=1. A read is issued in any cycle with bus_gnt=1; the issued address is {cx, cy}.
  - Counter advance: on an issued read, cx increments. cx=GRID_W-1 wraps cx to 0 and increments cy.
  - Issuing the read for (GRID_W-1, GRID_H-1) -> DRAIN.
  - DRAIN: bus_req=0. When both pipeline stages are empty -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE. busy falls in the same cycle IDLE is entered.
- Address output: presents the current counter value whenever in SCAN. The counter holds while bus_gnt=0, so no cell is skipped or repeated.
- Pipeline: stage 1 registers the valid flag and the (x, y) tag of an issued read. Stage 2 registers the tag and q, and asserts plot.
- Latency: plot for a cell is asserted exactly 2 cycles after the cycle its address was issued with bus_gnt=1.
- Grant loss: deasserting bus_gnt mid-sweep stalls issue only. An in-flight read still completes and plots.
- SKIP_BLANK=1: stage 2 suppresses plot when q=3'b000. x, y and colour still update.
- start while busy (SCAN, DRAIN, DONE) is ignored and not queued.
- Reset mid-sweep: immediate return to IDLE. plot and bus_req drop asynchronously and the pipeline is flushed. The next start restarts at (0,0).
- Counter widths: cx is 8 bits and cy is 7 bits. Neither is ever allowed to reach GRID_W or GRID_H.
- Sweep length with bus_gnt held high:
  - 19200 issue cycles; first plot 3 cycles after start is sampled.
  - frame_done asserted in the cycle after the last plot.

Decomposition:
- Shared package holds:
  - GRID_W and GRID_H.
  - Colour constants: COL_EMPTY=3'b000, plus one per player.
  - The address packing helper {x[7:0], y[6:0]}.
  - The scanner state encoding.
- Sub-module scan_counter: raster x/y counter with enable, wrap and last-cell flag, instantiated once.

Test Plan:
- Reset: assert reset with no clock -> plot=0, bus_req=0, busy=0, frame_done=0, address=0.
- Full sweep:
  - Setup: bus_gnt tied 1; RAM preloaded with colour = x[2:0]^y[2:0]; pulse start.
  - Expect 19200 plots in row-major order, with colour matching the preload.
  - First plot at (0,0) 2 cycles after address 0 is issued.
  - Last plot at (159,119); frame_done exactly once, the next cycle.
- Grant stall:
  - Stimulus: drop bus_gnt for 5 cycles when address = {8'd10, 7'd3}.
  - Expect the address to hold at that value during the stall, the in-flight plot for (9,3) to still occur, and no missing or duplicate cells across the sweep (count = 19200).
- start while busy: pulse start mid-SCAN and during DONE -> exactly one frame_done, no second sweep.
- Reset mid-sweep: assert reset at cell (80,60) -> plot=0 and busy=0 immediately. The next start produces its first plot at (0,0).
- SKIP_BLANK=1: RAM all 3'b000 except (5,5)=3'b100 -> exactly one plot, with x=5, y=5, colour=3'b100. frame_done still pulses.

Source files
------------

// File: rtl/ram_scanner_pkg.sv
// ram_scanner_pkg
// Shared definitions for the colour-RAM scanner: grid geometry, colour
// constants, the {x, y} address packing helper and the scanner FSM encoding.
package ram_scanner_pkg;

    localparam int GRID_W = 160;
    localparam int GRID_H = 120;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ADDR_W = X_W + Y_W;
    localparam int COL_W  = 3;

    localparam logic [COL_W-1:0] COL_EMPTY   = 3'b000;
    localparam logic [COL_W-1:0] COL_PLAYER1 = 3'b100;
    localparam logic [COL_W-1:0] COL_PLAYER2 = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } scan_state_e;

    // RAM address layout used by every client of the colour RAM.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] px,
                                                    input logic [Y_W-1:0] py);
        return {px, py};
    endfunction

endpackage

// File: rtl/ram_scanner_if.sv
// ram_scanner_if
// Arbitrated colour-RAM read port.
//   bus_req  : client -> arbiter, client wants the port
//   bus_gnt  : arbiter -> client, port owned this cycle
//   address  : client -> RAM, {x, y}
//   q        : RAM -> client, read data
// Handshake: a read is issued on every rising edge where bus_req and bus_gnt
// are both high; the client must hold address stable while bus_req is high
// and bus_gnt is low. q carries the data for that read in the following
// cycle. Neither side may make bus_gnt depend on anything but bus_req.
interface ram_scanner_if;

    logic        bus_req;
    logic        bus_gnt;
    logic [14:0] address;
    logic [2:0]  q;

    modport master (
        output bus_req,
        output address,
        input  bus_gnt,
        input  q
    );

    modport slave (
        input  bus_req,
        input  address,
        output bus_gnt,
        output q
    );

endinterface

// File: rtl/ram_scanner_scan_counter.sv
// ram_scanner_scan_counter
// Raster x/y counter for the scanner. Advances x on en, wrapping to the next
// row at the end of each row, and back to (0,0) after the last cell.
//   CLOCK_50, reset : clock, async active-high reset
//   en              : advance one cell
//   clr             : synchronous return to (0,0)
//   cx, cy          : current cell
//   last            : current cell is (GRID_W-1, GRID_H-1)
module ram_scanner_scan_counter #(
    parameter int GRID_W = 160,
    parameter int GRID_H = 120
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    localparam logic [7:0] X_LAST = 8'(GRID_W - 1);
    localparam logic [6:0] Y_LAST = 7'(GRID_H - 1);

    assign last = (cx == X_LAST) && (cy == Y_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (clr) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= (cy == Y_LAST) ? 7'd0 : cy + 7'd1;
            end else begin
                cx <= cx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ram_scanner.sv
// ram_scanner
// Sweeps the 160x120 colour RAM in row-major order on each start pulse and
// emits one plot strobe per cell (x, y, colour) to the VGA adapter. The RAM
// port is shared with other clients through the bus_req/bus_gnt handshake.
//   CLOCK_50, reset : clock, async active-high reset
//   start           : begin a sweep (only honoured in IDLE)
//   bus             : arbitrated RAM read port (master side)
//   x, y, colour    : plot coordinates and colour
//   plot            : one-cycle strobe per plotted cell
//   busy            : sweep in progress (any state but IDLE)
//   frame_done      : one-cycle pulse at the end of the sweep
//   state_dbg       : current FSM state encoding
module ram_scanner #(
    parameter int GRID_W     = ram_scanner_pkg::GRID_W,
    parameter int GRID_H     = ram_scanner_pkg::GRID_H,
    parameter bit SKIP_BLANK = 1'b0
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    ram_scanner_if.master       bus,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [2:0]          colour,
    output logic                plot,
    output logic                busy,
    output logic                frame_done,
    output logic [1:0]          state_dbg
);

    import ram_scanner_pkg::*;

    scan_state_e state, state_nxt;

    logic       issue;
    logic       last_cell;
    logic [7:0] cx;
    logic [6:0] cy;

    // Pipeline stage 1: tag of the read whose data arrives on q this cycle.
    logic       s1_valid;
    logic [7:0] s1_x;
    logic [6:0] s1_y;

    assign issue     = (state == S_SCAN) && bus.bus_gnt;
    assign state_dbg = state;

    ram_scanner_scan_counter #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_scan_counter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (issue),
        .clr      (state == S_IDLE),
        .cx       (cx),
        .cy       (cy),
        .last     (last_cell)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.bus_req = 1'b0;
        bus.address = '0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                bus.bus_req = 1'b1;
                bus.address = pack_addr(cx, cy);
                if (issue && last_cell) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Once stage 1 is empty, the last plot (if any) is being
                // shown this cycle and stage 2 empties at the same edge, so
                // frame_done lands in the cycle right after the last plot.
                if (!s1_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_x <= cx;
                s1_y <= cy;
            end
            // Stage 2: coordinates and colour always follow a valid read;
            // only the strobe is suppressed for blank cells.
            plot <= s1_valid && (!SKIP_BLANK || (bus.q != COL_EMPTY));
            if (s1_valid) begin
                x      <= s1_x;
                y      <= s1_y;
                colour <= bus.q;
            end
        end
    end

endmodule
